// File: rtl/mbist_pkg.sv
// Fault-kind encodings shared by the MBIST controller, the fault responder
// and their testbenches.
//   FT_W          : width of the fault_type field
//   FK_NONE..FK_CPL: 3-bit fault-kind codes
package mbist_pkg;
  localparam int FT_W = 3;

  typedef logic [FT_W-1:0] fault_kind_t;

  localparam fault_kind_t FK_NONE = 3'd0;
  localparam fault_kind_t FK_SA0  = 3'd1;
  localparam fault_kind_t FK_SA1  = 3'd2;
  localparam fault_kind_t FK_INV  = 3'd3;
  localparam fault_kind_t FK_TR   = 3'd4;
  localparam fault_kind_t FK_WB   = 3'd5;
  localparam fault_kind_t FK_TFR  = 3'd6;
  localparam fault_kind_t FK_CPL  = 3'd7;

  function automatic logic fault_active(input logic en, input fault_kind_t kind);
    return en && (kind != FK_NONE);
  endfunction
endpackage

// File: rtl/sram_fault_responder_if.sv
// Memory port between the MBIST controller (master) and the memory (slave).
//   cs/we/re/addr/wdata : access request, driven by the master
//   rdata/rvalid        : read result, driven by the memory
interface sram_fault_responder_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  cs;
  logic                  we;
  logic                  re;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;

  modport master (output cs, we, re, addr, wdata, input rdata, rvalid);
  modport slave  (input cs, we, re, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/sram_fault_responder_rd.sv
// Read-latency pipeline: DEPTH-stage valid+data shift register.
//   clk, reset_n  : clock, async active-low reset (clears all stages)
//   in_valid_i/in_data_i   : read result captured on the accept edge
//   out_valid_o/out_data_o : last stage, DEPTH-1 cycles after capture
module sram_rd_pipe #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o
);
  logic [DEPTH-1:0]      vld_q;
  logic [DATA_WIDTH-1:0] dat_q [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= in_valid_i;
      dat_q[0] <= in_data_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_valid_o = vld_q[DEPTH-1];
  assign out_data_o  = dat_q[DEPTH-1];
endmodule

// File: rtl/sram_fault_responder.sv
// Single-port SRAM responder for the MBIST memory slot with one injectable
// word-level fault and a programmable read latency.
//   clk, reset_n   : clock, async active-low reset
//   bus (slave)    : cs/we/re/addr/wdata in, rdata/rvalid out
//   fault_enable   : master fault enable
//   fault_addr     : aggressor word address
//   fault_type     : fault kind (mbist_pkg FK_*)
//   fault_target   : victim address for coupling faults
//   fault_hits     : saturating count of accesses altered by the fault
module sram_fault_responder
  import mbist_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int HIT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  sram_fault_responder_if.slave bus,
  input  logic                  fault_enable,
  input  logic [ADDR_WIDTH-1:0] fault_addr,
  input  logic [FT_W-1:0]       fault_type,
  input  logic [ADDR_WIDTH-1:0] fault_target,
  output logic [HIT_WIDTH-1:0]  fault_hits
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("sram_fault_responder: READ_LATENCY must be in 1..4");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_fire, rd_fire, hit;
  logic [DATA_WIDTH-1:0] raw, store_val, rd_val, stored;
  logic                  wr_en, flip_en, wr_bad, rd_bad;
  logic                  pipe_v;
  logic [DATA_WIDTH-1:0] pipe_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rvalid_q;
  logic [HIT_WIDTH-1:0]  fault_hits_q, fault_hits_d;

  assign wr_fire = bus.cs & bus.we;
  assign rd_fire = bus.cs & bus.re;
  assign raw     = mem[bus.addr];
  assign hit     = fault_active(fault_enable, fault_type) && (bus.addr == fault_addr);

  always_comb begin
    store_val = bus.wdata;
    wr_en     = wr_fire;
    flip_en   = 1'b0;
    rd_val    = raw;
    if (hit) begin
      case (fault_type)
        FK_SA0: rd_val = '0;
        FK_SA1: rd_val = '1;
        FK_INV: rd_val = ~raw;
        FK_TR:  store_val = raw & bus.wdata;
        FK_WB:  wr_en = 1'b0;
        FK_TFR: store_val = raw | bus.wdata;
        FK_CPL: flip_en = wr_fire && (bus.wdata != raw) && (fault_target != fault_addr);
        default: ;
      endcase
    end
  end

  // What the cell holds after this edge; a write is faulty when that differs from wdata.
  assign stored = wr_en ? store_val : raw;
  assign wr_bad = wr_fire && (stored != bus.wdata);
  assign rd_bad = rd_fire && (rd_val != raw);

  always_comb begin
    fault_hits_d = fault_hits_q;
    if ((wr_bad || rd_bad || flip_en) && (fault_hits_q != '1))
      fault_hits_d = fault_hits_q + {{(HIT_WIDTH-1){1'b0}}, 1'b1};
  end

  // Array is intentionally not reset. The victim flip is a second write port.
  always_ff @(posedge clk) begin
    if (wr_en)   mem[bus.addr]     <= store_val;
    if (flip_en) mem[fault_target] <= ~mem[fault_target];
  end

  // Stage 0 captures on the accept edge; the output register adds the final cycle.
  sram_rd_pipe #(
    .DEPTH      (READ_LATENCY),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd_pipe (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid_i  (rd_fire),
    .in_data_i   (rd_val),
    .out_valid_o (pipe_v),
    .out_data_o  (pipe_d)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      fault_hits_q <= '0;
    end else begin
      rvalid_q     <= pipe_v;
      fault_hits_q <= fault_hits_d;
      if (pipe_v) rdata_q <= pipe_d;
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign fault_hits = fault_hits_q;
endmodule

// File: tb/tb_sram_fault_responder.sv
module tb_sram_fault_responder;
  import mbist_pkg::*;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1_n = 1'b0;
  logic        rst3_n = 1'b0;
  logic        fault_enable;
  logic [7:0]  fault_addr, fault_target;
  logic [2:0]  fault_type;
  logic [2:0]  hits1;
  logic [15:0] hits3;

  sram_fault_responder_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) b1 ();
  sram_fault_responder_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) b3 ();

  sram_fault_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_LATENCY(1), .HIT_WIDTH(3)) dut1 (
    .clk(clk), .reset_n(rst1_n), .bus(b1.slave),
    .fault_enable(fault_enable), .fault_addr(fault_addr), .fault_type(fault_type),
    .fault_target(fault_target), .fault_hits(hits1));

  sram_fault_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_LATENCY(3), .HIT_WIDTH(16)) dut3 (
    .clk(clk), .reset_n(rst3_n), .bus(b3.slave),
    .fault_enable(fault_enable), .fault_addr(fault_addr), .fault_type(fault_type),
    .fault_target(fault_target), .fault_hits(hits3));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          vec = 0;
  int          bad = 0;
  exp_t        q1[$];
  exp_t        q3[$];
  logic [31:0] last_rd [2];
  bit          prev_rn [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vec++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic drv(input bit sel, input logic c, input logic w, input logic r,
                     input logic [7:0] a, input logic [31:0] d);
    if (sel) begin
      b3.cs = c; b3.we = w; b3.re = r; b3.addr = a; b3.wdata = d;
    end else begin
      b1.cs = c; b1.we = w; b1.re = r; b1.addr = a; b1.wdata = d;
    end
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
    drv(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
  endtask

  task automatic cfg(input logic en, input logic [2:0] ft, input logic [7:0] fa, input logic [7:0] tg);
    fault_enable = en; fault_type = ft; fault_addr = fa; fault_target = tg;
  endtask

  task automatic push(input bit sel, input logic [31:0] e);
    exp_t x;
    x.data = e;
    x.due  = cyc + 1 + (sel ? 3 : 1);
    if (sel) q3.push_back(x); else q1.push_back(x);
  endtask

  task automatic wr(input bit sel, input logic [7:0] a, input logic [31:0] d);
    drv(sel, 1'b1, 1'b1, 1'b0, a, d);
    @(negedge clk);
  endtask

  task automatic rd(input bit sel, input logic [7:0] a, input logic [31:0] e, input bit expect_it);
    drv(sel, 1'b1, 1'b0, 1'b1, a, 32'd0);
    if (expect_it) push(sel, e);
    @(negedge clk);
  endtask

  task automatic mon(input bit sel);
    logic        v, rn, have;
    logic [31:0] d;
    exp_t        e;
    v  = sel ? b3.rvalid : b1.rvalid;
    d  = sel ? b3.rdata : b1.rdata;
    rn = sel ? rst3_n : rst1_n;
    if (v === 1'b1) begin
      vec++;
      have = sel ? (q3.size() > 0) : (q1.size() > 0);
      if (!have) begin
        bad++;
        $display("FAIL rvalid_unexpected dut%0d: got rdata %h at cyc %0d, required no rvalid", sel ? 3 : 1, d, cyc);
      end else begin
        if (sel) e = q3.pop_front(); else e = q1.pop_front();
        if (d !== e.data || cyc != e.due) begin
          bad++;
          $display("FAIL rd_result dut%0d: got %h at cyc %0d, required %h at cyc %0d",
                   sel ? 3 : 1, d, cyc, e.data, e.due);
        end
      end
    end else if (rn && prev_rn[sel]) begin
      vec++;
      if (d !== last_rd[sel]) begin
        bad++;
        $display("FAIL rdata_hold dut%0d: got %h, required %h", sel ? 3 : 1, d, last_rd[sel]);
      end
    end
    last_rd[sel] = d;
    prev_rn[sel] = rn;
  endtask

  always @(posedge clk) begin
    #2;
    mon(1'b0);
    mon(1'b1);
  end

  initial begin
    idle();
    cfg(1'b0, FK_NONE, 8'd0, 8'd0);
    repeat (3) @(negedge clk);
    rst1_n = 1'b1;
    rst3_n = 1'b1;
    @(negedge clk);
    chk("reset_rdata1", b1.rdata, 32'd0);
    chk("reset_rvalid1", {31'd0, b1.rvalid}, 32'd0);
    chk("reset_hits1", {29'd0, hits1}, 32'd0);
    chk("reset_rdata3", b3.rdata, 32'd0);
    chk("reset_hits3", {16'd0, hits3}, 32'd0);

    // No fault
    wr(0, 8'd12, 32'hA5A5_A5A5);
    rd(0, 8'd12, 32'hA5A5_A5A5, 1);
    idle(); @(negedge clk);
    chk("nofault_hits", {29'd0, hits1}, 32'd0);

    // SA0 at 12
    cfg(1'b1, FK_SA0, 8'd12, 8'd0);
    wr(0, 8'd12, 32'hFFFF_FFFF);
    rd(0, 8'd12, 32'h0000_0000, 1);
    wr(0, 8'd13, 32'h1234_5678);
    rd(0, 8'd13, 32'h1234_5678, 1);
    idle(); @(negedge clk);
    chk("sa0_hits", {29'd0, hits1}, 32'd1);

    // TFR then TR at 45
    cfg(1'b1, FK_TFR, 8'd45, 8'd0);
    wr(0, 8'd45, 32'hFFFF_FFFF);
    wr(0, 8'd45, 32'h0000_0000);
    rd(0, 8'd45, 32'hFFFF_FFFF, 1);
    idle(); @(negedge clk);
    chk("tfr_hits", {29'd0, hits1}, 32'd2);
    cfg(1'b1, FK_TR, 8'd45, 8'd0);
    wr(0, 8'd45, 32'h0000_0000);
    wr(0, 8'd45, 32'hFFFF_FFFF);
    rd(0, 8'd45, 32'h0000_0000, 1);
    idle(); @(negedge clk);
    chk("tr_hits", {29'd0, hits1}, 32'd3);

    // CPL 100 -> 101
    cfg(1'b0, FK_NONE, 8'd0, 8'd0);
    wr(0, 8'd101, 32'h0F0F_0F0F);
    wr(0, 8'd100, 32'h0000_0000);
    cfg(1'b1, FK_CPL, 8'd100, 8'd101);
    wr(0, 8'd100, 32'h0000_0001);
    rd(0, 8'd101, 32'hF0F0_F0F0, 1);
    wr(0, 8'd100, 32'h0000_0001);
    rd(0, 8'd101, 32'hF0F0_F0F0, 1);
    rd(0, 8'd100, 32'h0000_0001, 1);
    idle(); @(negedge clk);
    chk("cpl_hits", {29'd0, hits1}, 32'd4);

    // WB at 7
    cfg(1'b0, FK_NONE, 8'd0, 8'd0);
    wr(0, 8'd7, 32'h0000_0011);
    cfg(1'b1, FK_WB, 8'd7, 8'd0);
    wr(0, 8'd7, 32'h0000_0022);
    rd(0, 8'd7, 32'h0000_0011, 1);
    idle(); @(negedge clk);
    chk("wb_hits", {29'd0, hits1}, 32'd5);

    // SA1 on an all-ones word changes nothing; INV drives the 3-bit counter into saturation
    cfg(1'b1, FK_SA1, 8'd12, 8'd0);
    rd(0, 8'd12, 32'hFFFF_FFFF, 1);
    idle(); @(negedge clk);
    chk("sa1_nochange_hits", {29'd0, hits1}, 32'd5);
    cfg(1'b1, FK_INV, 8'd13, 8'd0);
    rd(0, 8'd13, 32'hEDCB_A987, 1);
    idle(); @(negedge clk);
    chk("inv_hits", {29'd0, hits1}, 32'd6);
    rd(0, 8'd13, 32'hEDCB_A987, 1);
    rd(0, 8'd13, 32'hEDCB_A987, 1);
    idle(); @(negedge clk);
    chk("hits_saturate", {29'd0, hits1}, 32'd7);
    cfg(1'b0, FK_INV, 8'd13, 8'd0);
    rd(0, 8'd13, 32'h1234_5678, 1);
    idle(); @(negedge clk);

    // Simultaneous write+read returns old data; cs low does nothing
    wr(0, 8'd20, 32'hAAAA_0000);
    drv(0, 1'b1, 1'b1, 1'b1, 8'd20, 32'h0000_5555);
    push(0, 32'hAAAA_0000);
    @(negedge clk);
    rd(0, 8'd20, 32'h0000_5555, 1);
    drv(0, 1'b0, 1'b1, 1'b1, 8'd20, 32'h0000_DEAD);
    @(negedge clk);
    rd(0, 8'd20, 32'h0000_5555, 1);
    // Back-to-back reads
    rd(0, 8'd12, 32'hFFFF_FFFF, 1);
    rd(0, 8'd13, 32'h1234_5678, 1);
    rd(0, 8'd7,  32'h0000_0011, 1);
    idle(); repeat (3) @(negedge clk);
    chk("final_hits1", {29'd0, hits1}, 32'd7);

    // READ_LATENCY=3 pipelining
    wr(1, 8'd0, 32'h0000_0100);
    wr(1, 8'd1, 32'h0000_0101);
    wr(1, 8'd2, 32'h0000_0102);
    rd(1, 8'd0, 32'h0000_0100, 1);
    rd(1, 8'd1, 32'h0000_0101, 1);
    rd(1, 8'd2, 32'h0000_0102, 1);
    idle(); repeat (6) @(negedge clk);
    chk("lat3_drained", q3.size(), 32'd0);

    // Reset after the second accept drops both in-flight results
    rd(1, 8'd1, 32'd0, 0);
    rd(1, 8'd2, 32'd0, 0);
    idle();
    rst3_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midreset_rvalid", {31'd0, b3.rvalid}, 32'd0);
    rst3_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("postreset_rdata3", b3.rdata, 32'd0);
    chk("postreset_rvalid3", {31'd0, b3.rvalid}, 32'd0);
    chk("hits3", {16'd0, hits3}, 32'd0);

    for (int i = 0; i < 20 && (q1.size() > 0 || q3.size() > 0); i++) @(negedge clk);
    if (q1.size() > 0 || q3.size() > 0) begin
      vec++;
      bad++;
      $display("FAIL rvalid_timeout: got %0d results outstanding, required 0", q1.size() + q3.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule

// File: doc/sram_fault_responder.md
Name: sram_fault_responder

Overview:
- Synthesizable, memory-side responder to the MBIST controller's memory port (cs/we/re/addr/wdata, answered with rdata).
- Holds a 2^ADDR_WIDTH x DATA_WIDTH single-port array behind a programmable read-latency pipeline.
- Injects one configurable word-level fault (FK encoding 0-7), so MBIST can be exercised on FPGA without the behavioural model.
- Drop-in for the memory slot under mbist_controller; adds rvalid and a fault-hit counter for on-chip observation.

Parameters:
- ADDR_WIDTH, 8, address bits; depth = 2^ADDR_WIDTH.
- DATA_WIDTH, 32, word width.
- READ_LATENCY, 1, cycles from read accept to rdata; legal 1..4, elaboration error otherwise.
- HIT_WIDTH, 16, width of fault_hits counter.

Ports:
- clk, input, 1, single clock; everything rising-edge.
- reset_n, input, 1, asynchronous active-low reset.
- cs, input, 1, chip select; we/re ignored when low.
- we, input, 1, write strobe (qualified by cs).
- re, input, 1, read strobe (qualified by cs).
- addr, input, ADDR_WIDTH, access address.
- wdata, input, DATA_WIDTH, write data.
- rdata, output, DATA_WIDTH, read data; holds last value between reads.
- rvalid, output, 1, one-cycle pulse when rdata carries a new read result.
- fault_enable, input, 1, master fault enable; 0 gives a fault-free memory.
- fault_addr, input, ADDR_WIDTH, faulty (aggressor) word address.
- fault_type, input, 3, 0 none, 1 SA0, 2 SA1, 3 INV, 4 TR, 5 WB, 6 TFR, 7 CPL.
- fault_target, input, ADDR_WIDTH, victim address; used by CPL only.
- fault_hits, output, HIT_WIDTH, saturating count of accesses where a fault altered the result.

Behaviour:
- Reset (async assert, sync release): rdata=0, rvalid=0, fault_hits=0, latency pipeline cleared. Array contents are not reset.
- Fault config is sampled live on the cycle of each access; mid-test changes affect only later accesses.
- A fault is active when fault_enable=1 and fault_type!=0.
- Write (cs&we): updates mem[addr] at the clock edge. When the fault is active and addr==fault_addr:
  - SA0/SA1/INV: stored normally (the fault applies on read).
  - TR (rising transition fails): mem <= old & wdata.
  - WB: write discarded.
  - TFR (falling transition fails): mem <= old | wdata.
  - CPL: write stored normally; if wdata!=old and fault_target!=fault_addr, mem[fault_target] <= ~mem[fault_target] in the same cycle.
- Read (cs&re): raw = mem[addr] (pre-write value if we is also set; read-before-write). When the fault is active and addr==fault_addr:
  - SA0 returns 0.
  - SA1 returns all ones.
  - INV returns ~raw.
  - All other types return raw.
- Latency: a read accepted at edge N drives rdata and pulses rvalid for one cycle at edge N+READ_LATENCY.
- Back-to-back reads are fully pipelined, one result per cycle. rdata is unchanged when rvalid=0.
- fault_hits increments by 1 when an access is faulty: a faulty read value differs from raw, a faulty write stored value differs from wdata, or a CPL flip occurs. It saturates at all ones.
- Simultaneous we&re on one address: write and read both act; read sees old data.
- Reset asserted mid-read: in-flight results are dropped and no rvalid is issued after release.
- cs low: no access and no counter change; the pipeline continues to drain.

Decomposition:
- Shared package mbist_pkg holds FK_NONE/SA0/SA1/INV/TR/WB/TFR/CPL localparams (3-bit) and fault_type width.
- mbist_controller and testbenches import the same constants.
- One sub-module, sram_rd_pipe: READ_LATENCY-deep valid+data shift register with async reset.

Test Plan:
- No fault: write 0xA5A5A5A5 to 12, read 12 -> rdata=0xA5A5A5A5 with rvalid exactly READ_LATENCY cycles after accept; fault_hits=0.
- SA0 at 12: write 0xFFFFFFFF, read 12 -> 0x00000000; read 13 -> written value; fault_hits=1.
- TFR at 45: write 0xFFFFFFFF then 0x00000000, read -> 0xFFFFFFFF. TR at 45: write 0, then 0xFFFFFFFF, read -> 0x00000000.
- CPL 100->101: mem[101]=0x0F0F0F0F, write 0x1 to 100 (old 0) -> read 101 = 0xF0F0F0F0. Rewrite 0x1 to 100 -> no further flip.
- WB at 7: write 0x11 then 0x22, read 7 -> 0x11. Full mbist_controller run with this responder -> fail_flag=1, fail_addr=7.
- READ_LATENCY=3: reads to 0,1,2 on consecutive cycles -> three consecutive rvalid pulses in order. Reset asserted after the second accept -> no rvalid after release, rdata=0.
